// File: rtl/mem_wb_pipe_stage_pkg.sv
// Shared definitions for the MEM->WB pipeline stage: default widths, skid states,
// and the bit layout of the packed {address,value,rd,memToReg,regWrite} payload.
package mem_wb_pipe_stage_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned RD_W_DEF = 5;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Payload field offsets, LSB first.
  localparam int unsigned REGWRITE_OFS = 0;
  localparam int unsigned MEMTOREG_OFS = 1;
  localparam int unsigned RD_OFS       = 2;

  function automatic int unsigned value_ofs(input int unsigned rd_w);
    return RD_OFS + rd_w;
  endfunction

  function automatic int unsigned addr_ofs(input int unsigned xlen, input int unsigned rd_w);
    return value_ofs(rd_w) + xlen;
  endfunction

  function automatic int unsigned payload_w(input int unsigned xlen, input int unsigned rd_w);
    return addr_ofs(xlen, rd_w) + xlen;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready stage with a 2-entry skid buffer and synchronous flush;
// in_ready and out_valid are decoded from the state register only.
module pipe_skid_buf
  import mem_wb_pipe_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] out_q, skid_q;
  logic             load_out, load_skid, move_skid;
  logic             in_beat, out_beat;

  assign in_ready  = (state_q != SKID_FULL);
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = out_q;
  assign in_beat   = in_valid & in_ready;
  assign out_beat  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SKID_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_out)       out_q <= in_data;
      else if (move_skid) out_q <= skid_q;
      if (load_skid)      skid_q <= in_data;
    end
  end

  // Next state; flush overrides any same-cycle in-beat.
  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (in_beat) begin
          state_d  = SKID_ONE;
          load_out = 1'b1;
        end
      end
      SKID_ONE: begin
        if (in_beat && out_beat) begin
          load_out = 1'b1;
        end else if (out_beat) begin
          state_d = SKID_EMPTY;
        end else if (in_beat) begin
          state_d   = SKID_FULL;
          load_skid = 1'b1;
        end
      end
      SKID_FULL: begin
        if (out_beat) begin
          state_d   = SKID_ONE;
          move_skid = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    if (flush) begin
      state_d   = SKID_EMPTY;
      load_out  = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB valid/ready pipeline stage with flush, optional skid buffer, and a
// forwarding tap taken from the output register.
module mem_wb_pipe_stage
  import mem_wb_pipe_stage_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned RD_W    = RD_W_DEF,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] value,
  input  logic [RD_W-1:0] rd,
  input  logic            memToReg,
  input  logic            regWrite,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] address_reg,
  output logic [XLEN-1:0] value_reg,
  output logic [RD_W-1:0] rd_reg,
  output logic            memToReg_reg,
  output logic            regWrite_reg,
  output logic            fwd_valid,
  output logic [XLEN-1:0] fwd_data
);

  localparam int unsigned PL_W     = payload_w(XLEN, RD_W);
  localparam int unsigned ADDR_LSB = addr_ofs(XLEN, RD_W);
  localparam int unsigned VAL_LSB  = value_ofs(RD_W);

  logic [PL_W-1:0] pl_in, pl_out;

  assign pl_in = {address, value, rd, memToReg, regWrite};

  generate
    if (SKID_EN) begin : g_skid
      pipe_skid_buf #(.WIDTH(PL_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pl_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pl_out)
      );
    end else begin : g_single
      logic            valid_q;
      logic [PL_W-1:0] pl_q;

      assign in_ready  = out_ready | ~valid_q;
      assign out_valid = valid_q;
      assign pl_out    = pl_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q <= 1'b0;
          pl_q    <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
          valid_q <= 1'b1;
          pl_q    <= pl_in;
        end else if (out_ready) begin
          valid_q <= 1'b0;
        end
      end
    end
  endgenerate

  assign address_reg  = pl_out[ADDR_LSB +: XLEN];
  assign value_reg    = pl_out[VAL_LSB +: XLEN];
  assign rd_reg       = pl_out[RD_OFS +: RD_W];
  assign memToReg_reg = pl_out[MEMTOREG_OFS];
  // Stale payload after a flush must never look like a register write.
  assign regWrite_reg = pl_out[REGWRITE_OFS] & out_valid;

  assign fwd_valid = regWrite_reg & (rd_reg != '0);
  assign fwd_data  = memToReg_reg ? value_reg : address_reg;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Directed bench for the skid-buffered stage plus a randomized scoreboard run
// on the single-register variant.
module tb_mem_wb_pipe_stage;

  logic clk = 1'b0;
  logic reset, flush;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Skid-buffer instance (directed tests)
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] address, value, address_reg, value_reg, fwd_data;
  logic [4:0]  rd, rd_reg;
  logic        memToReg, regWrite, memToReg_reg, regWrite_reg, fwd_valid;

  mem_wb_pipe_stage #(.XLEN(64), .RD_W(5), .SKID_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .address(address), .value(value), .rd(rd), .memToReg(memToReg), .regWrite(regWrite),
    .out_valid(out_valid), .out_ready(out_ready),
    .address_reg(address_reg), .value_reg(value_reg), .rd_reg(rd_reg),
    .memToReg_reg(memToReg_reg), .regWrite_reg(regWrite_reg),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data)
  );

  // Single-register instance (random scoreboard test)
  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [63:0] s_address, s_value, s_address_reg, s_value_reg, s_fwd_data;
  logic [4:0]  s_rd_reg;
  logic        s_memToReg_reg, s_regWrite_reg, s_fwd_valid;

  mem_wb_pipe_stage #(.XLEN(64), .RD_W(5), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .address(s_address), .value(s_value), .rd(5'd7), .memToReg(1'b0), .regWrite(1'b1),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .address_reg(s_address_reg), .value_reg(s_value_reg), .rd_reg(s_rd_reg),
    .memToReg_reg(s_memToReg_reg), .regWrite_reg(s_regWrite_reg),
    .fwd_valid(s_fwd_valid), .fwd_data(s_fwd_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] v, input logic [4:0] r,
                       input logic m, input logic w);
    address  = a;
    value    = v;
    rd       = r;
    memToReg = m;
    regWrite = w;
  endtask

  initial begin
    logic [63:0] sb_q[$];
    logic [63:0] seq;
    logic        ib, ob;
    int          budget;

    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    drive(64'h99, 64'h0, 5'd3, 1'b0, 1'b1);
    s_flush = 1'b0; s_in_valid = 1'b1; s_out_ready = 1'b0;
    s_address = 64'h99; s_value = 64'h0;

    // 1: reset held two cycles with in_valid asserted
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0; s_in_valid = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_regwrite", 64'(regWrite_reg), 64'd0);
    check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_addr_reg", address_reg, 64'd0);
    check("rst0_out_valid", 64'(s_out_valid), 64'd0);
    check("rst0_in_ready", 64'(s_in_ready), 64'd1);

    // 2: streaming with out_ready held high
    out_ready = 1'b1; in_valid = 1'b1;
    drive(64'h10, 64'h0, 5'd1, 1'b0, 1'b0);
    tick();
    check("str_v1", 64'(out_valid), 64'd1);
    check("str_a1", address_reg, 64'h10);
    drive(64'h20, 64'h0, 5'd1, 1'b0, 1'b0);
    tick();
    check("str_v2", 64'(out_valid), 64'd1);
    check("str_a2", address_reg, 64'h20);
    drive(64'h30, 64'h0, 5'd1, 1'b0, 1'b0);
    tick();
    check("str_v3", 64'(out_valid), 64'd1);
    check("str_a3", address_reg, 64'h30);
    in_valid = 1'b0;
    tick();
    check("str_drain", 64'(out_valid), 64'd0);

    // 3: stall with three beats offered, then release
    out_ready = 1'b0; in_valid = 1'b1;
    drive(64'h10, 64'h0, 5'd1, 1'b0, 1'b0);
    tick();
    check("stl_rdy1", 64'(in_ready), 64'd1);
    check("stl_a1", address_reg, 64'h10);
    drive(64'h20, 64'h0, 5'd1, 1'b0, 1'b0);
    tick();
    check("stl_rdy_full", 64'(in_ready), 64'd0);
    drive(64'h30, 64'h0, 5'd1, 1'b0, 1'b0);
    tick();
    check("stl_rdy_hold", 64'(in_ready), 64'd0);
    check("stl_a_hold", address_reg, 64'h10);
    out_ready = 1'b1;
    tick();
    check("stl_a2", address_reg, 64'h20);
    check("stl_rdy_rel", 64'(in_ready), 64'd1);
    tick();
    check("stl_a3", address_reg, 64'h30);
    in_valid = 1'b0;
    tick();
    check("stl_empty", 64'(out_valid), 64'd0);

    // 4: flush a full stage with a beat offered in the same cycle
    out_ready = 1'b0; in_valid = 1'b1;
    drive(64'h40, 64'h0, 5'd2, 1'b0, 1'b1);
    tick();
    drive(64'h50, 64'h0, 5'd2, 1'b0, 1'b1);
    tick();
    check("fl_full", 64'(in_ready), 64'd0);
    drive(64'h60, 64'h0, 5'd2, 1'b0, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_regwrite", 64'(regWrite_reg), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_fwd_valid", 64'(fwd_valid), 64'd0);
    tick();
    check("fl_no_ghost1", 64'(out_valid), 64'd0);
    tick();
    check("fl_no_ghost2", 64'(out_valid), 64'd0);

    // 5: forwarding tap
    in_valid = 1'b1;
    drive(64'hBEEF, 64'hDEAD, 5'd5, 1'b1, 1'b1);
    tick();
    check("fwd_valid", 64'(fwd_valid), 64'd1);
    check("fwd_data", fwd_data, 64'hDEAD);
    check("fwd_regwrite", 64'(regWrite_reg), 64'd1);
    check("fwd_rd", 64'(rd_reg), 64'd5);
    drive(64'hBEEF, 64'hDEAD, 5'd0, 1'b1, 1'b1);
    tick();
    check("fwd_rd0_valid", 64'(fwd_valid), 64'd0);
    check("fwd_rd0_regwrite", 64'(regWrite_reg), 64'd1);
    drive(64'hBEEF, 64'hDEAD, 5'd3, 1'b0, 1'b1);
    tick();
    check("fwd_alu_data", fwd_data, 64'hBEEF);
    check("fwd_alu_valid", 64'(fwd_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    check("fwd_bubble", 64'(fwd_valid), 64'd0);

    // 6: single-register variant, random valid/ready with scoreboard
    seq = 64'd1;
    for (int c = 0; c < 10000; c++) begin
      s_in_valid  = 1'($urandom_range(0, 1));
      s_out_ready = 1'($urandom_range(0, 1));
      s_address   = seq;
      s_value     = 64'($urandom);
      #1;
      ib = s_in_valid & s_in_ready;
      ob = s_out_valid & s_out_ready;
      if (ob) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          check("sb_order", s_address_reg, sb_q.pop_front());
        end
      end
      if (ib) begin
        sb_q.push_back(seq);
        seq++;
      end
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0; s_out_ready = 1'b1;
    budget = 0;
    #1;
    while (s_out_valid && budget < 10) begin
      if (sb_q.size() != 0) check("sb_drain", s_address_reg, sb_q.pop_front());
      @(posedge clk);
      #2;
      budget++;
    end
    check("sb_drain_idle", 64'(s_out_valid), 64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    // Flush on the single-register variant
    s_out_ready = 1'b0; s_in_valid = 1'b1; s_address = 64'h77;
    tick();
    check("fl0_loaded", 64'(s_out_valid), 64'd1);
    check("fl0_fwd", 64'(s_fwd_valid), 64'd1);
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0; s_in_valid = 1'b0;
    check("fl0_out_valid", 64'(s_out_valid), 64'd0);
    check("fl0_regwrite", 64'(s_regWrite_reg), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
